m_div_seq: RTL and testbench
============================

Name: m_div_seq

Overview:
Multi-cycle radix-2 restoring divider that replaces the single-cycle combinational div/rem path of the ALU. It also generates the stall that freezes the PC and register write for the duration of a division. The controller decodes a div/rem/divu/remu instruction and pulses i_start. The CPU holds the instruction until o_valid, then writes o_result to rd and advances the PC.

Parameters:
WIDTH, 32, operand/result width in bits; iteration count equals WIDTH.

Ports:
i_clk  input  1  clock, all state updates on rising edge
i_reset  input  1  asynchronous, active-high reset
i_start  input  1  request a new operation; sampled only in IDLE
i_kill  input  1  abort current operation (pipeline flush / trap)
i_is_rem  input  1  1 = return remainder, 0 = return quotient
i_signed  input  1  1 = signed (div/rem), 0 = unsigned (divu/remu)
i_dividend  input  WIDTH  rs1 value
i_divisor  input  WIDTH  rs2 value
o_busy  output  1  high in CALC state
o_stall  output  1  combinational: (IDLE & i_start & ~i_kill) | CALC; holds PC and blocks reg write
o_valid  output  1  high for exactly one cycle (DONE state); result is final
o_result  output  WIDTH  quotient or remainder; held stable until the next accepted start

Behaviour:
- Reset (async, any time): state=IDLE, o_valid=0, o_busy=0, o_result=0, iteration counter=0, internal regs cleared.
- States: IDLE, CALC, DONE.
- IDLE:
  - On an edge with i_start=1 and i_kill=0, latch operands, i_is_rem and i_signed; all later input changes are ignored.
  - Divisor==0 -> DONE next edge (fast path): quotient=all ones, remainder=dividend (raw).
  - Signed overflow (i_signed, dividend=1<<(WIDTH-1), divisor=all ones) -> DONE next edge: quotient=dividend, remainder=0.
  - Otherwise -> CALC with counter=0, partial remainder=0, shift register=|dividend|.
- CALC:
  - Each edge performs one restoring step: shift {rem,quot} left by 1; trial = rem - |divisor| on WIDTH+1 bits; if non-negative, rem=trial and quot LSB=1.
  - Counter increments each step. On the edge completing step WIDTH-1, go to DONE and load o_result.
- Sign fix (signed only):
  - Quotient negated iff dividend and divisor signs differ.
  - Remainder takes the sign of the dividend.
  - Unsigned mode does no correction.
- DONE: o_valid=1 for one cycle; unconditionally -> IDLE next edge. i_start during DONE is ignored; it is re-sampled in IDLE.
- Latency, normal path: start edge E0; o_valid visible during the cycle after edge E0+WIDTH (WIDTH+1 cycles of stall including the start cycle).
- Latency, fast paths: o_valid visible during the cycle after edge E0+1.
- o_result changes only on entry to DONE; otherwise it holds its last value (0 after reset).
- i_kill:
  - In CALC or DONE: -> IDLE next edge; o_valid deasserts; o_result unchanged.
  - In IDLE: suppresses start acceptance.
  - i_kill has priority over i_start.
- o_busy and o_stall are 0 in DONE, so the CPU advances in the same cycle it consumes o_result.
- Width rules:
  - All arithmetic is unsigned internally on magnitudes.
  - |x| = two's-complement negate when signed and x[WIDTH-1]=1. |0x80000000| = 0x80000000 as unsigned, which is valid.

Test Plan:
- Signed div: i_signed=1, i_is_rem=0, 100/7 -> o_valid exactly 32 cycles after start edge, o_result=14. Same with i_is_rem=1 -> 2. o_stall high throughout the stall window.
- Signed sign rules: -7/2 -> 0xFFFFFFFD (-3); -7 rem 2 -> 0xFFFFFFFF (-1); 7 rem -2 -> 1.
- Divide by zero: 5/0 div -> 0xFFFFFFFF; 5 rem 0 -> 5. In both cases o_valid on the second cycle after the start edge.
- Overflow and unsigned: 0x80000000 / 0xFFFFFFFF signed -> 0x80000000, rem -> 0, both fast path. Unsigned 0xFFFFFFFF/2 -> 0x7FFFFFFF in 32 cycles.
- Kill: i_kill at cycle 10 of CALC -> IDLE next edge, no o_valid pulse, o_result keeps the previous value. A new start immediately after completes correctly.
- Async reset: assert i_reset mid-CALC between clock edges -> outputs 0 and state IDLE immediately, without a clock edge. After release, 100/7 completes with 14.

Source files
------------

// File: rtl/m_div_seq.sv
// Multi-cycle radix-2 restoring divider for div/rem/divu/remu, with CPU stall generation.
// One quotient bit is produced per cycle. Divide-by-zero and signed overflow take a one-cycle fast path.
module m_div_seq #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic             i_kill,
  input  logic             i_is_rem,
  input  logic             i_signed,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  output logic             o_busy,
  output logic             o_stall,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_result
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e           state_q,    state_d;
  logic [CNT_W-1:0] cnt_q,      cnt_d;
  logic [WIDTH-1:0] rem_q,      rem_d;
  logic [WIDTH-1:0] quot_q,     quot_d;
  logic [WIDTH-1:0] dvsr_q,     dvsr_d;
  logic             is_rem_q,   is_rem_d;
  logic             neg_quo_q,  neg_quo_d;
  logic             neg_rem_q,  neg_rem_d;
  logic             fast_q,     fast_d;
  logic [WIDTH-1:0] fast_res_q, fast_res_d;
  logic [WIDTH-1:0] result_q,   result_d;
  logic             valid_q,    valid_d;
  logic             busy_q,     busy_d;

  logic [WIDTH-1:0] dvnd_abs;
  logic [WIDTH-1:0] dvsr_abs;
  logic             div_zero;
  logic             sgn_ovf;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] rem_step;
  logic [WIDTH-1:0] quot_step;
  logic [WIDTH-1:0] quot_fin;
  logic [WIDTH-1:0] rem_fin;

  // Operand magnitudes and fast-path detection, evaluated on the live inputs in IDLE
  always_comb begin
    dvnd_abs = (i_signed && i_dividend[WIDTH-1]) ? (~i_dividend + WIDTH'(1)) : i_dividend;
    dvsr_abs = (i_signed && i_divisor[WIDTH-1])  ? (~i_divisor  + WIDTH'(1)) : i_divisor;
    div_zero = (i_divisor == '0);
    sgn_ovf  = i_signed && (i_dividend == MIN_NEG) && (i_divisor == '1);
  end

  // One restoring step: the bit shifted out of rem is kept as the trial's extra MSB
  always_comb begin
    trial     = {rem_q, quot_q[WIDTH-1]} - {1'b0, dvsr_q};
    rem_step  = trial[WIDTH] ? {rem_q[WIDTH-2:0], quot_q[WIDTH-1]} : trial[WIDTH-1:0];
    quot_step = {quot_q[WIDTH-2:0], ~trial[WIDTH]};
    quot_fin  = neg_quo_q ? (~quot_step + WIDTH'(1)) : quot_step;
    rem_fin   = neg_rem_q ? (~rem_step  + WIDTH'(1)) : rem_step;
  end

  // Next-state and datapath update
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rem_d      = rem_q;
    quot_d     = quot_q;
    dvsr_d     = dvsr_q;
    is_rem_d   = is_rem_q;
    neg_quo_d  = neg_quo_q;
    neg_rem_d  = neg_rem_q;
    fast_d     = fast_q;
    fast_res_d = fast_res_q;
    result_d   = result_q;
    valid_d    = 1'b0;
    busy_d     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (i_start && !i_kill) begin
          state_d    = S_CALC;
          cnt_d      = '0;
          rem_d      = '0;
          quot_d     = dvnd_abs;
          dvsr_d     = dvsr_abs;
          is_rem_d   = i_is_rem;
          neg_quo_d  = i_signed && (i_dividend[WIDTH-1] ^ i_divisor[WIDTH-1]);
          neg_rem_d  = i_signed && i_dividend[WIDTH-1];
          fast_d     = div_zero || sgn_ovf;
          if (div_zero) begin
            fast_res_d = i_is_rem ? i_dividend : '1;
          end else if (sgn_ovf) begin
            fast_res_d = i_is_rem ? '0 : i_dividend;
          end else begin
            fast_res_d = '0;
          end
        end
      end

      S_CALC: begin
        if (i_kill) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (fast_q) begin
          state_d  = S_DONE;
          result_d = fast_res_q;
        end else begin
          rem_d  = rem_step;
          quot_d = quot_step;
          cnt_d  = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            state_d  = S_DONE;
            cnt_d    = '0;
            result_d = is_rem_q ? rem_fin : quot_fin;
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d  = (state_d == S_CALC);
    valid_d = (state_d == S_DONE);
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      rem_q      <= '0;
      quot_q     <= '0;
      dvsr_q     <= '0;
      is_rem_q   <= 1'b0;
      neg_quo_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      fast_q     <= 1'b0;
      fast_res_q <= '0;
      result_q   <= '0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rem_q      <= rem_d;
      quot_q     <= quot_d;
      dvsr_q     <= dvsr_d;
      is_rem_q   <= is_rem_d;
      neg_quo_q  <= neg_quo_d;
      neg_rem_q  <= neg_rem_d;
      fast_q     <= fast_d;
      fast_res_q <= fast_res_d;
      result_q   <= result_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
    end
  end

  // Stall is combinational so the PC freezes in the very cycle the start is presented
  assign o_stall  = ((state_q == S_IDLE) && i_start && !i_kill) || (state_q == S_CALC);
  assign o_busy   = busy_q;
  assign o_valid  = valid_q;
  assign o_result = result_q;

endmodule

// File: tb/tb_m_div_seq.sv
// Self-checking bench for m_div_seq: directed cases plus randomized operations against an arithmetic model.
module tb_m_div_seq;

  localparam int unsigned W = 32;
  localparam logic [W-1:0] MIN_NEG = 32'h8000_0000;

  logic         clk;
  logic         rst;
  logic         start;
  logic         kill;
  logic         is_rem;
  logic         sgn;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         stall;
  logic         valid;
  logic [W-1:0] result;

  int n_checks = 0;
  int n_errors = 0;
  logic [W-1:0] last_res = '0;

  m_div_seq #(.WIDTH(W)) dut (
    .i_clk      (clk),
    .i_reset    (rst),
    .i_start    (start),
    .i_kill     (kill),
    .i_is_rem   (is_rem),
    .i_signed   (sgn),
    .i_dividend (dividend),
    .i_divisor  (divisor),
    .o_busy     (busy),
    .o_stall    (stall),
    .o_valid    (valid),
    .o_result   (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: RISC-V M-extension division semantics in plain arithmetic
  function automatic logic [W-1:0] ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic s, input logic r);
    logic signed [W-1:0] sa;
    logic signed [W-1:0] sb;
    sa = a;
    sb = b;
    if (b == '0) return r ? a : '1;
    if (s && a == MIN_NEG && b == '1) return r ? '0 : a;
    if (s) return r ? W'(sa % sb) : W'(sa / sb);
    return r ? (a % b) : (a / b);
  endfunction

  function automatic int ref_lat(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    if (b == '0 || (s && a == MIN_NEG && b == '1)) return 1;
    return int'(W);
  endfunction

  // Present a start at the current (post-edge) time and consume the start edge
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s, input logic r);
    dividend = a;
    divisor  = b;
    sgn      = s;
    is_rem   = r;
    start    = 1'b1;
    #1;
    check("stall_on_start", W'(stall), W'(1));
    @(posedge clk);
    #1;
    start    = 1'b0;
    dividend = $urandom;
    divisor  = $urandom;
    sgn      = 1'($urandom);
    is_rem   = 1'($urandom);
  endtask

  // Count edges from the start edge until o_valid, checking stall/busy on the way
  task automatic wait_result(input string tag, input logic [W-1:0] exp, input int exp_lat);
    int  n;
    logic bad;
    n   = 1;
    bad = 1'b0;
    while (!valid && n <= 40) begin
      if (!(stall && busy)) bad = 1'b1;
      @(posedge clk);
      #1;
      n++;
    end
    if (!valid) n = 99;
    check({tag, "_lat"}, W'(n - 1), W'(exp_lat));
    check({tag, "_stall_win"}, W'(bad), W'(0));
    check({tag, "_res"}, result, exp);
    check({tag, "_done_nostall"}, W'({busy, stall}), W'(0));
    last_res = exp;
  endtask

  task automatic finish_op(input string tag);
    @(posedge clk);
    #1;
    check({tag, "_valid_drop"}, W'(valid), W'(0));
    check({tag, "_hold"}, result, last_res);
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic s, input logic r, input logic [W-1:0] exp);
    start_op(a, b, s, r);
    wait_result(tag, exp, ref_lat(a, b, s));
    finish_op(tag);
  endtask

  initial begin
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         s;
    logic         r;
    rst = 1'b1; start = 1'b0; kill = 1'b0; is_rem = 1'b0; sgn = 1'b0;
    dividend = '0; divisor = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", W'(valid), W'(0));
    check("rst_busy", W'(busy), W'(0));
    check("rst_stall", W'(stall), W'(0));
    check("rst_result", result, '0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Directed sign, fast-path and unsigned cases
    run_op("sdiv_100_7", 32'd100, 32'd7, 1'b1, 1'b0, 32'd14);
    run_op("srem_100_7", 32'd100, 32'd7, 1'b1, 1'b1, 32'd2);
    run_op("sdiv_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0, 32'hFFFF_FFFD);
    run_op("srem_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, 1'b1, 32'hFFFF_FFFF);
    run_op("srem_7_m2", 32'd7, 32'hFFFF_FFFE, 1'b1, 1'b1, 32'd1);
    run_op("div_5_0", 32'd5, 32'd0, 1'b1, 1'b0, 32'hFFFF_FFFF);
    run_op("rem_5_0", 32'd5, 32'd0, 1'b0, 1'b1, 32'd5);
    run_op("srem_m5_0", 32'hFFFF_FFFB, 32'd0, 1'b1, 1'b1, 32'hFFFF_FFFB);
    run_op("ovf_div", MIN_NEG, 32'hFFFF_FFFF, 1'b1, 1'b0, MIN_NEG);
    run_op("ovf_rem", MIN_NEG, 32'hFFFF_FFFF, 1'b1, 1'b1, 32'd0);
    run_op("udiv_max_2", 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b0, 32'h7FFF_FFFF);
    run_op("udiv_min_m1", MIN_NEG, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'd0);
    run_op("sdiv_min_2", MIN_NEG, 32'd2, 1'b1, 1'b0, 32'hC000_0000);

    // Kill in IDLE suppresses the start
    start = 1'b1; kill = 1'b1; dividend = 32'd9; divisor = 32'd3;
    #1;
    check("kill_idle_stall", W'(stall), W'(0));
    @(posedge clk);
    #1;
    start = 1'b0; kill = 1'b0;
    check("kill_idle_busy", W'(busy), W'(0));
    repeat (3) @(posedge clk);
    #1;
    check("kill_idle_novalid", W'(valid), W'(0));

    // Kill at CALC cycle 10, then an immediate restart
    start_op(32'd1000, 32'd3, 1'b0, 1'b0);
    repeat (9) @(posedge clk);
    #1;
    check("kill_pre_busy", W'(busy), W'(1));
    kill = 1'b1;
    @(posedge clk);
    #1;
    kill = 1'b0;
    check("kill_busy", W'(busy), W'(0));
    check("kill_valid", W'(valid), W'(0));
    check("kill_hold", result, last_res);
    run_op("after_kill", 32'd100, 32'd7, 1'b1, 1'b0, 32'd14);

    // Start presented during DONE is ignored and taken on the following IDLE edge
    start_op(32'd50, 32'd5, 1'b0, 1'b0);
    wait_result("pre_done_start", 32'd10, int'(W));
    dividend = 32'd81; divisor = 32'd9; sgn = 1'b0; is_rem = 1'b0; start = 1'b1;
    @(posedge clk);
    #1;
    check("done_start_ignored", W'(busy), W'(0));
    start_op(32'd81, 32'd9, 1'b0, 1'b0);
    wait_result("done_restart", 32'd9, int'(W));
    finish_op("done_restart");

    // Asynchronous reset mid-CALC, between clock edges
    start_op(32'd100, 32'd7, 1'b1, 1'b0);
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("arst_busy", W'(busy), W'(0));
    check("arst_valid", W'(valid), W'(0));
    check("arst_result", result, '0);
    check("arst_stall", W'(stall), W'(0));
    #3;
    rst = 1'b0;
    last_res = '0;
    @(posedge clk);
    #1;
    run_op("post_rst", 32'd100, 32'd7, 1'b1, 1'b0, 32'd14);

    // Randomized operations with edge-case operand mixes
    for (int i = 0; i < 150; i++) begin
      a = $urandom;
      b = $urandom;
      s = 1'($urandom);
      r = 1'($urandom);
      case ($urandom_range(0, 7))
        0: b = '0;
        1: begin a = MIN_NEG; b = '1; s = 1'b1; end
        2: b = W'($urandom_range(1, 15));
        3: a = W'($urandom_range(0, 255));
        4: b = {1'b1, 31'($urandom)};
        default: ;
      endcase
      run_op("rand", a, b, s, r, ref_div(a, b, s, r));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
